// File: rtl/twos_com_rx.sv
// ---------------------------------------------------------------------------
// twos_com_rx
//   Serial receiver for the LSB-first stream produced by twos_com. Collects
//   WIDTH bits into a parallel word and offers it on a valid/ready port.
//
//   Optional feature macro: TWOS_COM_RX_DECODE_EN
//     defined   - each bit is passed through the serial two's-complement rule
//                 before storage, so dout recovers the converter's operand.
//     undefined - dout is the raw received word.
//
// Parameters:
//   WIDTH       bits per frame (>= 2)
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   start       frame-start strobe, coincident with bit 0
//   sin         serial data, LSB first
//   dout_ready  consumer accepts dout when high with dout_valid
//   dout        assembled word
//   dout_valid  dout holds an unconsumed word
//   busy        frame in progress
//   overrun     sticky: a completed word was dropped (cleared only by reset)
// ---------------------------------------------------------------------------
module twos_com_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sin,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_overrun;
`ifdef TWOS_COM_RX_DECODE_EN
    logic             r_seen;
`endif

    logic             w_take;
    logic [CW-1:0]    w_idx;
    logic             w_bit;
    logic             w_last;
    logic [WIDTH-1:0] w_word;

    // A start (in IDLE or as a restart in SHIFT) always takes bit 0 and
    // discards any partial word; w_word is the register contents including
    // this cycle's bit, so completion can load it directly.
    always_comb begin
        w_take = start || (r_state == SHIFT);
        w_idx  = start ? '0 : r_cnt;
`ifdef TWOS_COM_RX_DECODE_EN
        // the start bit is always evaluated with seen_one cleared
        w_bit  = (r_seen && !start) ? ~sin : sin;
`else
        w_bit  = sin;
`endif
        w_word        = start ? '0 : r_shift;
        w_word[w_idx] = w_bit;
        w_last        = w_take && (w_idx == LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
`ifdef TWOS_COM_RX_DECODE_EN
            r_seen    <= 1'b0;
`endif
        end else begin
            if (w_take) begin
                r_shift <= w_word;
                if (w_last) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_state <= SHIFT;
                    r_cnt   <= w_idx + 1'b1;
                end
`ifdef TWOS_COM_RX_DECODE_EN
                r_seen <= w_last ? 1'b0 : ((r_seen && !start) || sin);
`endif
            end

            // A completion either loads (slot free or being consumed this
            // edge) or is dropped and flagged; otherwise ready just drains.
            if (w_last) begin
                if (!r_valid || dout_ready) begin
                    r_dout  <= w_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (dout_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign busy       = (r_state == SHIFT);
    assign overrun    = r_overrun;

endmodule
